// File: rtl/cart_pkg.sv
// Shared cartridge definitions: header addresses, header byte offsets,
// mapper-select and RAM-size encodings, and the header probe FSM states.
package cart_pkg;

  // Cartridge header addresses
  localparam logic [14:0] HDR_FIRST = 15'h0134;
  localparam logic [14:0] HDR_TYPE  = 15'h0147;
  localparam logic [14:0] HDR_ROM   = 15'h0148;
  localparam logic [14:0] HDR_RAM   = 15'h0149;
  localparam logic [14:0] HDR_CSUM  = 15'h014D;

  // Offsets of the interesting bytes relative to HDR_FIRST (read index)
  localparam logic [4:0] IDX_TYPE = 5'(HDR_TYPE - HDR_FIRST);
  localparam logic [4:0] IDX_ROM  = 5'(HDR_ROM  - HDR_FIRST);
  localparam logic [4:0] IDX_RAM  = 5'(HDR_RAM  - HDR_FIRST);
  localparam logic [4:0] IDX_CSUM = 5'(HDR_CSUM - HDR_FIRST);

  // Mapper select, as consumed by the MBC-select mux
  typedef enum logic [1:0] {
    MBC_NONE  = 2'd0,
    MBC_MBC1  = 2'd1,
    MBC_UNSUP = 2'd3
  } mbc_sel_e;

  // External RAM size encoding, shared with the mapper blocks
  typedef enum logic [1:0] {
    RAM_NONE = 2'd0,
    RAM_2K   = 2'd1,
    RAM_8K   = 2'd2,
    RAM_32K  = 2'd3
  } ram_size_e;

  // Largest ROM size code the mappers understand
  localparam logic [7:0] ROM_CODE_MAX = 8'h06;

  // Header probe FSM states (also exported on the debug port)
  typedef enum logic [1:0] {
    ST_READ  = 2'd0,
    ST_CHECK = 2'd1,
    ST_DONE  = 2'd2
  } probe_state_e;

endpackage

// File: rtl/cart_header_decode.sv
// Combinational map from raw header bytes (type, ROM code, RAM code) to the
// mapper configuration. Purely combinational so it can be shared by other
// blocks that already hold the header bytes.
module cart_header_decode
  import cart_pkg::*;
(
  input  logic [7:0] type_i,
  input  logic [7:0] rom_i,
  input  logic [7:0] ram_i,
  output logic [1:0] mbc_sel_o,
  output logic [2:0] rom_size_o,
  output logic [1:0] ram_size_o,
  output logic       err_cfg_o
);

  logic rom_bad;
  logic ram_bad;
  logic type_bad;

  // Decode each field independently; any unsupported field raises err_cfg
  always_comb begin
    mbc_sel_o  = MBC_NONE;
    rom_size_o = rom_i[2:0];
    ram_size_o = RAM_NONE;
    rom_bad    = (rom_i > ROM_CODE_MAX);
    ram_bad    = 1'b0;
    type_bad   = 1'b0;

    case (ram_i)
      8'h00:   ram_size_o = RAM_NONE;
      8'h01:   ram_size_o = RAM_2K;
      8'h02:   ram_size_o = RAM_8K;
      8'h03:   ram_size_o = RAM_32K;
      default: begin
        ram_size_o = RAM_NONE;
        ram_bad    = 1'b1;
      end
    endcase

    case (type_i)
      8'h00, 8'h08, 8'h09: mbc_sel_o = MBC_NONE;
      8'h01, 8'h02, 8'h03: mbc_sel_o = MBC_MBC1;
      default: begin
        mbc_sel_o = MBC_UNSUP;
        type_bad  = 1'b1;
      end
    endcase

    err_cfg_o = rom_bad | ram_bad | type_bad;
  end

endmodule

// File: rtl/cart_header_probe.sv
// Boot-time cartridge header probe. Walks the ROM header 0x0134..0x014D over
// the ROM chip-select path, accumulates the header checksum, and publishes
// the decoded mapper configuration once the whole header has been read.
//
// Handshake: there is no valid/ready pair here. busy=1 means the probe owns
// the cartridge bus; done=1 (busy=0) means every result output is valid and
// held until the next CHECK. rescan is a one-cycle request honoured only
// while done=1.
module cart_header_probe
  import cart_pkg::*;
#(
  parameter int unsigned READ_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rescan,
  input  logic [7:0]  idata,
  output logic [14:0] oadr,
  output logic        ocs_rom,
  output logic        busy,
  output logic        done,
  output logic [7:0]  cart_type,
  output logic [1:0]  mbc_sel,
  output logic [2:0]  rom_size,
  output logic [1:0]  ram_size,
  output logic        err_csum,
  output logic        err_cfg,
  output logic [1:0]  dbg_state
);

  localparam logic [3:0] CNT_LAST = 4'(READ_CYCLES - 1);

  probe_state_e state_q, state_d;

  // run_q is low for the first cycle after reset/rescan so the bus stays
  // idle for one cycle before the first read window opens.
  logic       run_q;
  logic [4:0] idx_q;
  logic [3:0] cnt_q;
  logic [7:0] x_q;
  logic [7:0] ref_q;
  logic [7:0] type_byte_q;
  logic [7:0] rom_byte_q;
  logic [7:0] ram_byte_q;
  logic       last_cyc;

  logic [7:0] cart_type_q;
  logic [1:0] mbc_sel_q;
  logic [2:0] rom_size_q;
  logic [1:0] ram_size_q;
  logic       err_csum_q;
  logic       err_cfg_q;

  logic [1:0] dec_mbc_sel;
  logic [2:0] dec_rom_size;
  logic [1:0] dec_ram_size;
  logic       dec_err_cfg;

  assign last_cyc = run_q && (cnt_q == CNT_LAST);

  cart_header_decode u_decode (
    .type_i     (type_byte_q),
    .rom_i      (rom_byte_q),
    .ram_i      (ram_byte_q),
    .mbc_sel_o  (dec_mbc_sel),
    .rom_size_o (dec_rom_size),
    .ram_size_o (dec_ram_size),
    .err_cfg_o  (dec_err_cfg)
  );

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_READ;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_READ:  if (last_cyc && (idx_q == IDX_CSUM)) state_d = ST_CHECK;
      ST_CHECK: state_d = ST_DONE;
      ST_DONE:  if (rescan) state_d = ST_READ;
      default:  state_d = ST_READ;
    endcase
  end

  // Bus-facing and status outputs derived from the current state
  always_comb begin
    ocs_rom   = (state_q == ST_READ) && run_q;
    oadr      = ocs_rom ? (HDR_FIRST + 15'(idx_q)) : 15'h0000;
    busy      = (state_q != ST_DONE);
    done      = (state_q == ST_DONE);
    dbg_state = state_q;
  end

  // Read sequencing: cycle counter, byte index, checksum and byte latches
  always_ff @(posedge clk) begin
    if (reset) begin
      run_q       <= 1'b0;
      idx_q       <= 5'd0;
      cnt_q       <= 4'd0;
      x_q         <= 8'h00;
      ref_q       <= 8'h00;
      type_byte_q <= 8'h00;
      rom_byte_q  <= 8'h00;
      ram_byte_q  <= 8'h00;
    end else begin
      case (state_q)
        ST_READ: begin
          if (!run_q) begin
            run_q <= 1'b1;
            cnt_q <= 4'd0;
          end else if (last_cyc) begin
            cnt_q <= 4'd0;
            idx_q <= idx_q + 5'd1;
            if (idx_q == IDX_CSUM) ref_q <= idata;
            else                   x_q   <= x_q - idata - 8'd1;
            if (idx_q == IDX_TYPE) type_byte_q <= idata;
            if (idx_q == IDX_ROM)  rom_byte_q  <= idata;
            if (idx_q == IDX_RAM)  ram_byte_q  <= idata;
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        ST_DONE: begin
          if (rescan) begin
            run_q <= 1'b0;
            idx_q <= 5'd0;
            cnt_q <= 4'd0;
            x_q   <= 8'h00;
          end
        end
        default: ;
      endcase
    end
  end

  // Result registers: loaded in CHECK, error flags dropped on rescan
  always_ff @(posedge clk) begin
    if (reset) begin
      cart_type_q <= 8'h00;
      mbc_sel_q   <= MBC_NONE;
      rom_size_q  <= 3'd0;
      ram_size_q  <= RAM_NONE;
      err_csum_q  <= 1'b0;
      err_cfg_q   <= 1'b0;
    end else if (state_q == ST_CHECK) begin
      cart_type_q <= type_byte_q;
      mbc_sel_q   <= dec_mbc_sel;
      rom_size_q  <= dec_rom_size;
      ram_size_q  <= dec_ram_size;
      err_csum_q  <= (x_q != ref_q);
      err_cfg_q   <= dec_err_cfg;
    end else if ((state_q == ST_DONE) && rescan) begin
      err_csum_q  <= 1'b0;
      err_cfg_q   <= 1'b0;
    end
  end

  assign cart_type = cart_type_q;
  assign mbc_sel   = mbc_sel_q;
  assign rom_size  = rom_size_q;
  assign ram_size  = ram_size_q;
  assign err_csum  = err_csum_q;
  assign err_cfg   = err_cfg_q;

endmodule

// File: tb/tb_cart_header_probe.sv
// Directed bench for cart_header_probe: two instances (READ_CYCLES=2 and 1)
// each backed by a small cartridge ROM model driving idata from oadr.
module tb_cart_header_probe;
  import cart_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset    = 1'b1;
  logic rescan_a = 1'b0;
  logic rescan_b = 1'b0;

  // ---------------- DUT A (READ_CYCLES=2) ----------------
  logic [7:0]  rom_a [32];
  logic [7:0]  idata_a;
  logic [14:0] oadr_a;
  logic        ocs_a, busy_a, done_a, ecs_a, ecf_a;
  logic [7:0]  type_a;
  logic [1:0]  mbc_a, ram_a, dbg_a;
  logic [2:0]  romsz_a;
  logic [4:0]  ia;

  assign ia      = 5'(oadr_a - HDR_FIRST);
  assign idata_a = ocs_a ? rom_a[ia] : 8'hFF;

  cart_header_probe #(.READ_CYCLES(2)) dut_a (
    .clk(clk), .reset(reset), .rescan(rescan_a), .idata(idata_a),
    .oadr(oadr_a), .ocs_rom(ocs_a), .busy(busy_a), .done(done_a),
    .cart_type(type_a), .mbc_sel(mbc_a), .rom_size(romsz_a),
    .ram_size(ram_a), .err_csum(ecs_a), .err_cfg(ecf_a), .dbg_state(dbg_a)
  );

  // ---------------- DUT B (READ_CYCLES=1) ----------------
  logic [7:0]  rom_b [32];
  logic [7:0]  idata_b;
  logic [14:0] oadr_b;
  logic        ocs_b, busy_b, done_b, ecs_b, ecf_b;
  logic [7:0]  type_b;
  logic [1:0]  mbc_b, ram_b, dbg_b;
  logic [2:0]  romsz_b;
  logic [4:0]  ib;

  assign ib      = 5'(oadr_b - HDR_FIRST);
  assign idata_b = ocs_b ? rom_b[ib] : 8'hFF;

  cart_header_probe #(.READ_CYCLES(1)) dut_b (
    .clk(clk), .reset(reset), .rescan(rescan_b), .idata(idata_b),
    .oadr(oadr_b), .ocs_rom(ocs_b), .busy(busy_b), .done(done_b),
    .cart_type(type_b), .mbc_sel(mbc_b), .rom_size(romsz_b),
    .ram_size(ram_b), .err_csum(ecs_b), .err_cfg(ecf_b), .dbg_state(dbg_b)
  );

  // ---------------- observed-DUT mux ----------------
  int          sel = 0;
  logic [14:0] m_oadr;
  logic        m_ocs, m_busy, m_done, m_ecs, m_ecf;
  logic [7:0]  m_type;
  logic [1:0]  m_mbc, m_ram, m_dbg;
  logic [2:0]  m_rom;

  always_comb begin
    if (sel == 0) begin
      m_oadr = oadr_a; m_ocs = ocs_a; m_busy = busy_a; m_done = done_a;
      m_ecs = ecs_a; m_ecf = ecf_a; m_type = type_a; m_mbc = mbc_a;
      m_ram = ram_a; m_rom = romsz_a; m_dbg = dbg_a;
    end else begin
      m_oadr = oadr_b; m_ocs = ocs_b; m_busy = busy_b; m_done = done_b;
      m_ecs = ecs_b; m_ecf = ecf_b; m_type = type_b; m_mbc = mbc_b;
      m_ram = ram_b; m_rom = romsz_b; m_dbg = dbg_b;
    end
  end

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Build a header image; checksum byte = reference sum plus csum_off.
  task automatic fill(input int which, input logic [7:0] typ, input logic [7:0] rsz,
                      input logic [7:0] asz, input logic [7:0] csum_off);
    logic [7:0] h [32];
    logic [7:0] x;
    for (int i = 0; i < 32; i++) h[i] = 8'h30 + 8'(i * 7);
    h[19] = typ;
    h[20] = rsz;
    h[21] = asz;
    x = 8'h00;
    for (int i = 0; i < 25; i++) x = x - h[i] - 8'd1;
    h[25] = x + csum_off;
    if (which == 0) rom_a = h;
    else            rom_b = h;
  endtask

  // Reset, release, and follow one probe. Optional one-cycle reset when the
  // bus reaches byte abort_at, and optional rescan pulse at cycle rescan_at.
  task automatic run_probe(input int s, input int rc, input int abort_at,
                           input int rescan_at, output int done_cyc);
    int c, ocs_n, first_ocs, addr_bad;
    logic [14:0] exp_adr;
    bit aborted;
    sel = s;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    c = 0; ocs_n = 0; first_ocs = -1; addr_bad = 0; aborted = 0; done_cyc = -1;
    while (c < 400 && done_cyc < 0) begin
      @(negedge clk);
      c++;
      rescan_a = 1'b0;
      rescan_b = 1'b0;
      if (m_ocs) begin
        if (first_ocs < 0) first_ocs = c;
        exp_adr = HDR_FIRST + 15'(ocs_n / rc);
        if (m_oadr !== exp_adr) addr_bad++;
        ocs_n++;
      end
      if (c == rescan_at) begin
        if (s == 0) rescan_a = 1'b1;
        else        rescan_b = 1'b1;
      end
      if (abort_at >= 0 && !aborted && m_ocs && m_oadr == HDR_FIRST + 15'(abort_at)) begin
        reset = 1'b1;
        @(negedge clk);
        aborted = 1;
        chk("abort_ocs", m_ocs, 1'b0);
        chk("abort_oadr", m_oadr, 15'h0000);
        chk("abort_done", m_done, 1'b0);
        chk("abort_type", m_type, 8'h00);
        reset = 1'b0;
        c = 0; ocs_n = 0; first_ocs = -1;
      end
      if (m_done) begin
        done_cyc = c;
        chk("busy_at_done", m_busy, 1'b0);
      end
    end
    if (done_cyc < 0) chk("done_timeout", 0, 1);
    chk("first_ocs_cycle", first_ocs, 1);
    chk("ocs_cycles", ocs_n, 26 * rc);
    chk("addr_sequence_errs", addr_bad, 0);
  endtask

  // Pulse rescan while in DONE and time the new result.
  task automatic rescan_done(input int s, input int rc, input logic [1:0] old_mbc);
    int n;
    sel = s;
    if (s == 0) rescan_a = 1'b1;
    else        rescan_b = 1'b1;
    @(negedge clk);
    rescan_a = 1'b0;
    rescan_b = 1'b0;
    chk("rescan_done_drop", m_done, 1'b0);
    chk("rescan_busy", m_busy, 1'b1);
    chk("rescan_err_clr", {m_ecs, m_ecf}, 2'b00);
    chk("rescan_mbc_held", m_mbc, old_mbc);
    n = 0;
    while (!m_done && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("rescan_latency", n, 26 * rc + 2);
  endtask

  task automatic check_results(input string tag, input logic [7:0] typ, input logic [1:0] mbc,
                               input logic [2:0] rsz, input logic [1:0] asz,
                               input logic ecs, input logic ecf);
    chk({tag, "_type"}, m_type, typ);
    chk({tag, "_mbc"}, m_mbc, mbc);
    chk({tag, "_rom"}, m_rom, rsz);
    chk({tag, "_ram"}, m_ram, asz);
    chk({tag, "_csum"}, m_ecs, ecs);
    chk({tag, "_cfg"}, m_ecf, ecf);
    chk({tag, "_ocs"}, m_ocs, 1'b0);
    chk({tag, "_oadr"}, m_oadr, 15'h0000);
    chk({tag, "_state"}, m_dbg, ST_DONE);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int dc;
    fill(0, 8'h03, 8'h05, 8'h03, 8'h00);
    fill(1, 8'h03, 8'h05, 8'h03, 8'h00);

    // reset values on both instances
    reset = 1'b1;
    repeat (3) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      sel = s;
      #1;
      chk("rst_oadr", m_oadr, 15'h0000);
      chk("rst_ocs", m_ocs, 1'b0);
      chk("rst_busy", m_busy, 1'b1);
      chk("rst_done", m_done, 1'b0);
      chk("rst_type", m_type, 8'h00);
      chk("rst_mbc", m_mbc, 2'd0);
      chk("rst_rom", m_rom, 3'd0);
      chk("rst_ram", m_ram, 2'd0);
      chk("rst_errs", {m_ecs, m_ecf}, 2'b00);
    end

    // valid MBC1 header; rescan pulse during READ must be ignored
    run_probe(0, 2, -1, 10, dc);
    chk("mbc1_done_cycle", dc, 54);
    check_results("mbc1", 8'h03, 2'd1, 3'd5, 2'd3, 1'b0, 1'b0);

    // checksum byte off by one
    fill(0, 8'h03, 8'h05, 8'h03, 8'h01);
    run_probe(0, 2, -1, -1, dc);
    chk("csum_done_cycle", dc, 54);
    check_results("csum", 8'h03, 2'd1, 3'd5, 2'd3, 1'b1, 1'b0);

    // unsupported type, ROM code 7, RAM code 4
    fill(0, 8'h13, 8'h07, 8'h04, 8'h00);
    run_probe(0, 2, -1, -1, dc);
    chk("badcfg_done_cycle", dc, 54);
    check_results("badcfg", 8'h13, 2'd3, 3'd7, 2'd0, 1'b0, 1'b1);

    // READ_CYCLES=1 instance with address-stability bus model
    run_probe(1, 1, -1, -1, dc);
    chk("rc1_done_cycle", dc, 28);
    check_results("rc1", 8'h03, 2'd1, 3'd5, 2'd3, 1'b0, 1'b0);

    // reset while reading byte 10, then a clean probe
    fill(0, 8'h01, 8'h02, 8'h02, 8'h00);
    run_probe(0, 2, 10, -1, dc);
    chk("abort_done_cycle", dc, 54);
    check_results("abort", 8'h01, 2'd1, 3'd2, 2'd2, 1'b0, 1'b0);

    // swap cartridge, rescan from DONE
    fill(0, 8'h13, 8'h07, 8'h04, 8'h00);
    rescan_done(0, 2, 2'd1);
    check_results("rescan1", 8'h13, 2'd3, 3'd7, 2'd0, 1'b0, 1'b1);
    fill(0, 8'h08, 8'h00, 8'h01, 8'h00);
    rescan_done(0, 2, 2'd3);
    check_results("rescan2", 8'h08, 2'd0, 3'd0, 2'd1, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cart_header_probe.md
# cart_header_probe

Boot-time cartridge bus initiator that reads the header bytes 0x0134–0x014D over the ROM chip-select path, verifies the header checksum and derives the configuration that the cartridge mappers consume: `rom_size`, `ram_size` and the mapper select. It sits between the cartridge slot and the mapper instance, holding the CPU off the bus via `busy` until the header is decoded. It is the producer side of the mapper's size/configuration inputs.

## Interface

- `READ_CYCLES`, default 2: clock cycles each header read holds address and `ocs_rom` stable; legal range 1–15.
- `clk`  in  1  system clock
- `reset`  in  1  reset, synchronous, active-high
- `rescan`  in  1  single-cycle pulse; restarts the probe when `done`=1, ignored otherwise
- `idata`  in  8  cartridge data bus, valid in the last cycle of each read
- `oadr`  out  15  cartridge address A14..A0
- `ocs_rom`  out  1  ROM chip select, high for the whole read window
- `busy`  out  1  probe owns the bus; CPU accesses must be blocked
- `done`  out  1  header decoded; result outputs valid and stable
- `cart_type`  out  8  raw byte 0x0147
- `mbc_sel`  out  2  0 = no mapper, 1 = MBC1, 3 = unsupported
- `rom_size`  out  3  byte 0x0148, low 3 bits
- `ram_size`  out  2  encoded RAM size: 0 none, 1 2kB, 2 8kB, 3 32kB
- `err_csum`  out  1  header checksum mismatch
- `err_cfg`  out  1  ROM/RAM size code or cartridge type unsupported

## Operation

- States are READ, CHECK and DONE. Reset forces READ with index 0 and the cycle counter at 0.
- READ: `oadr` = 0x0134 + index and `ocs_rom` = 1. The cycle counter runs 0..READ_CYCLES-1. At count READ_CYCLES-1 the block samples `idata`, increments the index and clears the counter.
- Checksum accumulator `x` is 8 bits, cleared on entry to READ. For bytes 0x0134–0x014C it computes `x ← x − byte − 1` modulo 256. Byte 0x014D is stored as the reference.
- Bytes 0x0147, 0x0148 and 0x0149 are latched into internal registers as they are sampled.
- After index 25 (0x014D) is sampled, the FSM goes to CHECK for one cycle. In CHECK, `ocs_rom` = 0 and all outputs are computed and registered:
  - `err_csum` = (x ≠ ref).
  - `rom_size` = byte148[2:0]. If byte148 > 0x06, `err_cfg` is set.
  - RAM byte 0x00/0x01/0x02/0x03 maps to `ram_size` 0/1/2/3. Any other value sets `err_cfg` and forces `ram_size` = 0.
  - Type 0x00/0x08/0x09 gives `mbc_sel` = 0. Type 0x01–0x03 gives 1. Anything else gives 3 and sets `err_cfg`.
- DONE: `done` = 1 and `busy` = 0. Outputs hold. `ocs_rom` = 0 and `oadr` = 0.
- `rescan` in DONE returns the FSM to READ with index 0. `done` and the error flags clear that same edge. Result outputs keep their old values until the next CHECK.
- Errors do not stop the block: DONE is still reached, and the system decides what to do with the flags.

## Timing

- Reset values: `oadr` 0, `ocs_rom` 0, `busy` 1, `done` 0, `cart_type` 0, `mbc_sel` 0, `rom_size` 0, `ram_size` 0, `err_csum` 0, `err_cfg` 0.
- Cycle 0 is the first rising edge with `reset` = 0; at that edge the FSM leaves reset and enters READ. In cycles 1..26·READ_CYCLES, `ocs_rom` = 1.
- Byte k is sampled at the edge ending cycle k·READ_CYCLES + READ_CYCLES. The address changes only on that same edge.
- CHECK occupies one cycle. `done` = 1 from cycle 26·READ_CYCLES + 2, which is cycle 54 for the default of 2.
- `rescan` is registered, and READ starts on the following cycle.
- `reset` mid-read aborts immediately. The next probe starts from 0x0134, and no partial results are exposed.
- `rescan` outside DONE has no effect.

## Structure

- Shared package `cart_pkg` holds:
  - Header address constants: `HDR_FIRST` 0x0134, `HDR_TYPE` 0x0147, `HDR_ROM` 0x0148, `HDR_RAM` 0x0149, `HDR_CSUM` 0x014D.
  - `mbc_sel` encodings.
  - `ram_size` encodings, shared with the mapper blocks.
- Sub-module `cart_header_decode` is a combinational map from (type, rom, ram) bytes to (`mbc_sel`, `rom_size`, `ram_size`, `err_cfg`). It is reused by a future MBC-select mux.
- The FSM, counters and checksum accumulator live in `cart_header_probe`.

## Test plan

- Valid MBC1 header (type 0x03, rom 0x05, ram 0x03, correct checksum), READ_CYCLES=2 -> `done` at cycle 54, `mbc_sel`=1, `rom_size`=5, `ram_size`=3, both errors 0, `busy` falls the same cycle.
- Header identical except byte 0x014D is off by one -> `err_csum`=1, `err_cfg`=0, decoded sizes still reported.
- Type 0x13 with rom 0x07 and ram 0x04 -> `mbc_sel`=3, `ram_size`=0, `err_cfg`=1.
- READ_CYCLES=1 plus a bus model checking address stability -> 26 consecutive addresses 0x0134..0x014D, `done` at cycle 28.
- `reset` asserted for one cycle while reading byte 10 -> the bus restarts at 0x0134 and the final results match a clean probe.
- `rescan` pulse in DONE after swapping cartridge contents -> `done` drops next edge, new results appear 26·READ_CYCLES+2 cycles later; a `rescan` during READ is ignored.
